// File: rtl/program_loader.sv
// ============================================================================
// program_loader : framed byte-stream boot loader for 9-bit instruction memory
// Revision 1.0   : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module program_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [8:0] mem_wdata,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [8:0] word_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [8:0] r_len;
  logic [8:0] r_index;
  logic [7:0] r_sum;
  logic [7:0] r_lo;
  logic       w_accept;
  logic       w_hi_bad;
  logic       w_last;

  assign w_accept = rx_valid && rx_ready;
  assign w_hi_bad = |rx_data[7:1];
  assign w_last   = ((r_index + 9'd1) == r_len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next_state = S_LEN;
      end
      S_LEN: begin
        if (w_accept) w_next_state = S_LO;
      end
      S_LO: begin
        if (w_accept) w_next_state = S_HI;
      end
      S_HI: begin
        if (w_accept) begin
          if (w_hi_bad)    w_next_state = S_ERR;
          else if (w_last) w_next_state = S_CSUM;
          else             w_next_state = S_LO;
        end
      end
      S_CSUM: begin
        if (w_accept) w_next_state = (rx_data == r_sum) ? S_DONE : S_ERR;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (r_state)
      S_LEN, S_LO, S_HI, S_CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: a LEN byte of zero encodes a full 256-word image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len      <= 9'd0;
      r_index    <= 9'd0;
      r_sum      <= 8'd0;
      r_lo       <= 8'd0;
      mem_we     <= 1'b0;
      mem_addr   <= 8'd0;
      mem_wdata  <= 9'd0;
      word_count <= 9'd0;
    end else begin
      mem_we <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_LEN: begin
            r_len      <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            r_sum      <= rx_data;
            r_index    <= 9'd0;
            word_count <= 9'd0;
          end
          S_LO: begin
            r_lo  <= rx_data;
            r_sum <= r_sum + rx_data;
          end
          S_HI: begin
            if (!w_hi_bad) begin
              mem_we     <= 1'b1;
              mem_addr   <= BASE_ADDR + r_index[7:0];
              mem_wdata  <= {rx_data[0], r_lo};
              r_index    <= r_index + 9'd1;
              word_count <= word_count + 9'd1;
              r_sum      <= r_sum + rx_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// tb_program_loader : randomized self-checking bench for program_loader
// Revision 1.0      : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_data;

  logic [1:0] rdy, we, hold, busy, done, err;
  logic [7:0] addr [2];
  logic [8:0] wd [2];
  logic [8:0] wc [2];

  program_loader #(.BASE_ADDR(8'h00)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy[0]), .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wd[0]),
    .cpu_hold(hold[0]), .busy(busy[0]), .done(done[0]), .error(err[0]), .word_count(wc[0])
  );

  program_loader #(.BASE_ADDR(8'h10)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy[1]), .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wd[1]),
    .cpu_hold(hold[1]), .busy(busy[1]), .done(done[1]), .error(err[1]), .word_count(wc[1])
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [16:0] wr0 [$];
  logic [16:0] wr1 [$];
  logic [8:0]  words [$];

  always @(negedge clk) begin
    if (we[0] === 1'b1) wr0.push_back({addr[0], wd[0]});
    if (we[1] === 1'b1) wr1.push_back({addr[1], wd[1]});
  end

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rdy[0] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (rdy[0] !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL handshake_timeout: rx_ready=%b required 1", rdy[0]);
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Reference frame: LEN, {LO, HI} per word, then sum of all prior bytes xor'ed with csum_flip.
  task automatic run_frame(input int maxgap, input int start_at, input logic [7:0] csum_flip);
    logic [7:0] bytes [$];
    int sum;
    int n;
    n = words.size();
    sum = n % 256;
    bytes.push_back(8'(n % 256));
    for (int i = 0; i < n; i++) begin
      bytes.push_back(words[i][7:0]);
      bytes.push_back({7'd0, words[i][8]});
      sum = sum + words[i][7:0] + words[i][8];
    end
    bytes.push_back(8'(sum % 256) ^ csum_flip);
    for (int i = 0; i < bytes.size(); i++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      if (i == start_at) begin
        start_pulse();
        for (int d = 0; d < 2; d++) begin
          n_vec++;
          if (busy[d] !== 1'b1) begin
            n_err++;
            $display("FAIL start_mid_frame dut%0d: busy=%b required 1", d, busy[d]);
          end
        end
      end
      send_byte(bytes[i]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if ({rdy[d], hold[d], busy[d], done[d], err[d], we[d]} !== 6'b010000 ||
          addr[d] !== 8'd0 || wd[d] !== 9'd0 || wc[d] !== 9'd0) begin
        n_err++;
        $display("FAIL reset_values dut%0d: rdy/hold/busy/done/err/we=%b%b%b%b%b%b addr=%h wdata=%h wc=%0d required 010000 00 000 0",
                 d, rdy[d], hold[d], busy[d], done[d], err[d], we[d], addr[d], wd[d], wc[d]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame(input string tag, input int maxgap, input int start_at,
                            input logic [7:0] csum_flip);
    logic [4:0] exp_st;
    int n;
    wr0.delete(); wr1.delete();
    n = words.size();
    start_pulse();
    run_frame(maxgap, start_at, csum_flip);
    exp_st = (csum_flip == 8'd0) ? 5'b00010 : 5'b01001;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if ({rdy[d], hold[d], busy[d], done[d], err[d]} !== exp_st || wc[d] !== 9'(n)) begin
        n_err++;
        $display("FAIL %s_status dut%0d: rdy/hold/busy/done/err=%b%b%b%b%b wc=%0d required %b wc=%0d",
                 tag, d, rdy[d], hold[d], busy[d], done[d], err[d], wc[d], exp_st, n);
      end
      n_vec++;
      if (((d == 0) ? wr0.size() : wr1.size()) != n) begin
        n_err++;
        $display("FAIL %s_write_count dut%0d: got %0d required %0d", tag, d,
                 (d == 0) ? wr0.size() : wr1.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          logic [16:0] got, exp;
          got = (d == 0) ? wr0[i] : wr1[i];
          exp = {8'(((d == 0 ? 0 : 16) + i) % 256), words[i]};
          n_vec++;
          if (got !== exp) begin
            n_err++;
            $display("FAIL %s_write dut%0d #%0d: addr/data=%h/%h required %h/%h",
                     tag, d, i, got[16:9], got[8:0], exp[16:9], exp[8:0]);
          end
        end
      end
    end
  endtask

  task automatic load_basic_words();
    words.delete();
    words.push_back(9'h0A5); words.push_back(9'h1FF); words.push_back(9'h000);
  endtask

  task automatic load_random_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(9'($urandom));
  endtask

  task automatic test_basic();
    load_basic_words();
    test_frame("basic", 0, -1, 8'h00);
  endtask

  task automatic test_bad_checksum();
    load_basic_words();
    test_frame("bad_csum", 0, -1, 8'hA8);
    test_frame("recover", 0, -1, 8'h00);
  endtask

  task automatic test_bad_hi();
    wr0.delete(); wr1.delete();
    start_pulse();
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h02);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if ({rdy[d], hold[d], busy[d], done[d], err[d]} !== 5'b01001 || wc[d] !== 9'd0 ||
          ((d == 0) ? wr0.size() : wr1.size()) != 0) begin
        n_err++;
        $display("FAIL bad_hi dut%0d: rdy/hold/busy/done/err=%b%b%b%b%b wc=%0d writes=%0d required 01001 wc=0 writes=0",
                 d, rdy[d], hold[d], busy[d], done[d], err[d], wc[d],
                 (d == 0) ? wr0.size() : wr1.size());
      end
    end
  endtask

  task automatic test_full_256();
    load_random_words(256);
    test_frame("full256", 0, -1, 8'h00);
  endtask

  task automatic test_gaps_start();
    load_basic_words();
    test_frame("gaps_start", 3, 4, 8'h00);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      load_random_words($urandom_range(1, 40));
      test_frame("random", (k % 2) * 2, -1, 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    start_pulse();
    send_byte(8'h01);
    send_byte(8'h34);
    rx_valid = 1'b1;
    rx_data  = 8'h01;
    reset    = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if ({rdy[d], we[d], hold[d], busy[d]} !== 4'b0010 || wc[d] !== 9'd0) begin
        n_err++;
        $display("FAIL reset_mid dut%0d: rdy/we/hold/busy=%b%b%b%b wc=%0d required 0010 wc=0",
                 d, rdy[d], we[d], hold[d], busy[d], wc[d]);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    load_random_words(7);
    test_frame("after_reset", 1, -1, 8'h00);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_bad_hi();
    test_full_256();
    test_gaps_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_loader.md
# program_loader

Byte-stream boot loader that writes 9-bit instruction words into the write port of the CPU's instruction memory while holding the CPU in reset. It accepts a framed byte stream over a valid/ready handshake (length, payload, checksum), assembles each instruction from two bytes, and issues one write per instruction at consecutive addresses. On a verified checksum it releases the CPU; on any framing or checksum fault it keeps the CPU held and flags an error.

## Interface
- BASE_ADDR, 8'h00, instruction-memory address of the first loaded word.
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  single-cycle pulse; begins a load session (honoured only in IDLE, DONE, ERR)
- rx_data  input  8  stream byte
- rx_valid  input  1  rx_data valid; upstream holds rx_data stable until accepted
- rx_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  one-cycle instruction-memory write strobe
- mem_addr  output  8  write address
- mem_wdata  output  9  write data
- cpu_hold  output  1  keeps CPU (PC) in reset while high
- busy  output  1  session in progress
- done  output  1  last session completed with good checksum
- error  output  1  last session aborted (format or checksum)
- word_count  output  9  words written in current/last session (0..256)

## Operation
- Byte accepted when rx_valid && rx_ready on a rising edge. rx_ready high only in LEN, LO, HI, CSUM.
- Frame: LEN byte N (N=0 means 256 words), then per word LO byte (bits 7:0) and HI byte (bit 0 = instruction bit 8, bits 7:1 must be 0), then CSUM byte.
- Checksum: 8-bit sum mod 256 of LEN and every LO/HI byte; CSUM must equal it.
- States: IDLE -> LEN on start. LEN -> LO on accept (latch N, clear running sum to LEN, word_count := 0, index := 0). LO -> HI on accept (latch low byte). HI -> ERR if rx_data[7:1] != 0; else write, index++, -> LO if words remaining, else CSUM. CSUM -> DONE if match, else ERR. DONE/ERR -> LEN on start.
- Write: mem_addr = (BASE_ADDR + index) mod 256 (wraps 8'hFF -> 8'h00); mem_wdata = {hi[0], lo}; word_count increments with the strobe.
- cpu_hold: 1 in IDLE, LEN, LO, HI, CSUM, ERR; 0 only in DONE.
- busy = state in {LEN, LO, HI, CSUM}; done = state DONE; error = state ERR.
- start while busy: ignored. start and rx_valid same cycle in IDLE/DONE/ERR: byte not consumed (rx_ready low that cycle).
- Faulty HI byte: no write for that word; earlier writes remain in memory.
- Reset mid-session: state -> IDLE immediately; memory contents not restored.

## Timing
- Reset values: rx_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, busy 0, done 0, error 0, word_count 0.
- start at edge k -> state LEN, busy/rx_ready high after edge k; done/error clear same edge; cpu_hold high after edge k.
- Throughput one byte per cycle; N words take 2N+2 accepted bytes.
- mem_we asserted for exactly the cycle after the HI accept edge, addr/data valid with it; word_count updated on that same edge.
- CSUM accept edge -> DONE or ERR visible next cycle; cpu_hold falls with done rising. Final mem_we coincides with CSUM-state cycle at earliest; no conflict.
- rx_valid gaps of any length insert stall cycles only; no timeout.

## Test plan
- BASE_ADDR=0; reset, start, bytes 03, A5,00, FF,01, 00,00, A8 back-to-back -> writes (00,0A5),(01,1FF),(02,000); done=1, cpu_hold=0, word_count=3, error=0.
- Same frame with CSUM 00 -> three writes, then error=1, cpu_hold=1, done=0; start and correct frame -> done=1.
- LEN 02, LO 12, HI 02 -> error=1 after HI accept, no mem_we, word_count=0, rx_ready=0.
- BASE_ADDR=8'h10, LEN 00, 256 word pairs -> addresses 10..FF then 00..0F, word_count=256, done with correct sum.
- Random rx_valid gaps and a start pulse mid-frame -> identical writes to back-to-back case, start ignored, busy stays 1.
- Assert reset low during HI state -> same-cycle rx_ready=0, mem_we=0, cpu_hold=1, busy=0; after release and start, full load succeeds.
